// File: rtl/reset_request_arbiter.sv
// Round-robin arbiter for reset requests: grants one requester, drives a
// qualified reset pulse, then follows the downstream sequence to its ack.
module reset_request_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned PULSE_WIDTH = 8,
    parameter bit          PULSE_LEVEL = 1'b0,
    parameter int unsigned TIMEOUT     = 1023,
    parameter int unsigned HOLDOFF     = 16
) (
    input  logic               slowest_sync_clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic               ack_err,
    output logic               rst_pulse_out,
    input  logic               seq_active_in,
    output logic               busy,
    output logic [NUM_REQ-1:0] last_cause,
    output logic               cause_valid,
    output logic [7:0]         err_count
);

    localparam int unsigned PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WW   = $clog2(TIMEOUT + 1);

    localparam logic [PTRW:0]   LP_N   = (PTRW + 1)'(NUM_REQ);
    localparam logic [PTRW-1:0] LP_NM1 = PTRW'(NUM_REQ - 1);
    localparam logic [7:0]      LP_PW1 = 8'(PULSE_WIDTH - 1);
    localparam logic [7:0]      LP_HO1 = 8'(HOLDOFF - 1);
    localparam logic [WW-1:0]   LP_TO1 = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT_A,
        S_WAIT_R,
        S_ACK,
        S_HOLD
    } state_t;

    state_t             r_state;
    logic [PTRW-1:0]    r_ptr;
    logic [7:0]         r_pcnt;
    logic [7:0]         r_hcnt;
    logic [WW-1:0]      r_wcnt;
    logic [NUM_REQ-1:0] r_cause;
    logic               r_cause_valid;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_ack_err;
    logic               r_pulse;
    logic [7:0]         r_errc;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTRW-1:0]      w_off;
    logic [PTRW:0]        w_sum;
    logic [PTRW-1:0]      w_gidx;
    logic [PTRW-1:0]      w_nptr;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [7:0]           w_errc_inc;

    // Rotate requests so bit 0 is the requester at the pointer.
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[r_ptr +: NUM_REQ];

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PTRW'(k);
            end
        end
    end

    assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_gidx = (w_sum >= LP_N) ? PTRW'(w_sum - LP_N) : PTRW'(w_sum);
    assign w_nptr = (w_gidx == LP_NM1) ? '0 : w_gidx + 1'b1;
    assign w_gnt  = NUM_REQ'(1) << w_gidx;

    assign w_errc_inc = (r_errc == 8'hFF) ? r_errc : r_errc + 8'd1;

    always_ff @(posedge slowest_sync_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_pcnt        <= '0;
            r_hcnt        <= '0;
            r_wcnt        <= '0;
            r_cause       <= '0;
            r_cause_valid <= 1'b0;
            r_ack         <= '0;
            r_ack_err     <= 1'b0;
            r_pulse       <= !PULSE_LEVEL;
            r_errc        <= '0;
        end else begin
            r_ack     <= '0;
            r_ack_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_cause       <= w_gnt;
                        r_cause_valid <= 1'b1;
                        r_ptr         <= w_nptr;
                        r_pcnt        <= '0;
                        r_pulse       <= PULSE_LEVEL;
                        r_state       <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (r_pcnt == LP_PW1) begin
                        r_pulse <= !PULSE_LEVEL;
                        r_wcnt  <= '0;
                        r_state <= S_WAIT_A;
                    end else begin
                        r_pcnt <= r_pcnt + 8'd1;
                    end
                end
                S_WAIT_A: begin
                    // An already-active sequence is accepted immediately.
                    if (seq_active_in) begin
                        r_wcnt  <= '0;
                        r_state <= S_WAIT_R;
                    end else if (r_wcnt == LP_TO1) begin
                        r_ack     <= r_cause;
                        r_ack_err <= 1'b1;
                        r_errc    <= w_errc_inc;
                        r_state   <= S_ACK;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_WAIT_R: begin
                    if (!seq_active_in) begin
                        r_ack   <= r_cause;
                        r_state <= S_ACK;
                    end else if (r_wcnt == LP_TO1) begin
                        r_ack     <= r_cause;
                        r_ack_err <= 1'b1;
                        r_errc    <= w_errc_inc;
                        r_state   <= S_ACK;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_ACK: begin
                    r_hcnt  <= '0;
                    r_state <= (HOLDOFF == 0) ? S_IDLE : S_HOLD;
                end
                S_HOLD: begin
                    if (r_hcnt == LP_HO1) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack           = r_ack;
    assign ack_err       = r_ack_err;
    assign rst_pulse_out = r_pulse;
    assign busy          = (r_state != S_IDLE);
    assign last_cause    = r_cause;
    assign cause_valid   = r_cause_valid;
    assign err_count     = r_errc;

endmodule

// File: doc/reset_request_arbiter.md
Name: reset_request_arbiter

Overview:
- Collects software/hardware reset requests from NUM_REQ independent requesters, e.g. host register write, watchdog and pushbutton GPIO.
- Round-robin arbitrates between them and drives a single qualified reset pulse into the staged reset counter.
- Tracks the counter's sequence through completion and acknowledges the granted requester.
- Runs in the always-on domain. Its rst derives only from clock lock, never from the staged resets it produces.

Parameters:
NUM_REQ, 3, number of requesters (1..8)
PULSE_WIDTH, 8, active cycles of rst_pulse_out. Must be >= downstream counter active-width qualification.
PULSE_LEVEL, 0, active logic level of rst_pulse_out
TIMEOUT, 1023, max cycles allowed in each wait state (1..65535)
HOLDOFF, 16, dead cycles after ack before a new grant (0..255)

Ports:
slowest_sync_clk  input  1  sole clock
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  level reset requests. Held until own ack.
ack  output  NUM_REQ  one-cycle, one-hot completion strobe to the granted requester
ack_err  output  1  valid with ack. 1 = sequence timed out.
rst_pulse_out  output  1  to downstream counter's external reset input, polarity PULSE_LEVEL
seq_active_in  input  1  downstream last-stage reset (rst_3), high while the sequence runs
busy  output  1  high in any state other than IDLE
last_cause  output  NUM_REQ  one-hot grant of the most recent sequence. Held until the next grant.
cause_valid  output  1  set on first grant after rst, sticky
err_count  output  8  saturating count of timed-out sequences

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE; rr pointer=0; all counters 0.
  - ack=0, ack_err=0, rst_pulse_out=!PULSE_LEVEL, busy=0.
  - last_cause=0, cause_valid=0, err_count=0.
  - rst asserted mid-sequence aborts immediately: pulse returns inactive next edge, and no ack is issued for the aborted grant.
- States: IDLE -> PULSE -> WAIT_ASSERT -> WAIT_RELEASE -> ACK -> HOLDOFF -> IDLE.
- IDLE:
  - When any req bit is high at edge T, grant g = first set bit searching from pointer upward with wrap.
  - On that edge: latch g into last_cause, set cause_valid=1, set pointer=(g+1) mod NUM_REQ, go to PULSE.
- PULSE:
  - rst_pulse_out=PULSE_LEVEL for exactly PULSE_WIDTH cycles, registered, starting at T+1.
  - On the last cycle, load wait counter=0 and go to WAIT_ASSERT.
- WAIT_ASSERT:
  - seq_active_in=1 -> WAIT_RELEASE with wait counter cleared. Already-high input (e.g. lock loss) is accepted.
  - Wait counter reaches TIMEOUT -> ACK with error flag set.
- WAIT_RELEASE:
  - seq_active_in=0 -> ACK.
  - Wait counter reaches TIMEOUT -> ACK with error flag set.
- ACK:
  - Exactly one cycle: ack[g]=1, ack_err=error flag.
  - If error, err_count increments, saturating at 255.
  - Then go to HOLDOFF, or straight to IDLE if HOLDOFF=0.
- HOLDOFF: HOLDOFF cycles with req ignored, then IDLE.
- Request handling:
  - Requests are not latched. A req dropped before grant is lost, with no ack.
  - req of the granted requester may drop any time after grant without effect.
  - If it is still high after ack, it is re-arbitrated normally as a new request.
- Simultaneous requests: round-robin guarantees each of N continuously pending requesters is served within N sequences.
- Minimum grant-to-ack latency: PULSE_WIDTH + 3 cycles (one cycle each for WAIT_ASSERT, WAIT_RELEASE and ACK).
- Counter widths: wait counter is clog2(TIMEOUT+1) bits; pulse and holdoff counters are 8 bits. No counter wraps; each compares and exits on equality.
- busy=1 from T+1 through the last HOLDOFF cycle.

Test Plan:
- Single request: req=3'b001 at T, PULSE_WIDTH=8, model asserts seq_active_in at T+11 and drops it at T+60.
  - Expected: rst_pulse_out=0 on T+1..T+8; ack=3'b001 with ack_err=0 exactly one cycle after the cycle seq_active_in is first seen low; last_cause=001.
- Three simultaneous requests held continuously with pointer=0.
  - Expected: grants in order 001, 010, 100, each separated by full sequence + HOLDOFF; no requester acked twice before the others.
- Missing downstream: seq_active_in tied 0, TIMEOUT=1023.
  - Expected: ack with ack_err=1 exactly 1023 cycles after entering WAIT_ASSERT; err_count=1. Repeat 300 times -> err_count saturates at 255.
- Stuck downstream: seq_active_in tied 1.
  - Expected: passes WAIT_ASSERT in one cycle; ack_err=1 after TIMEOUT in WAIT_RELEASE.
- rst asserted during PULSE cycle 4.
  - Expected: next edge rst_pulse_out=1 (inactive), busy=0, ack never pulses, pointer=0, cause_valid=0.
- Request during HOLDOFF: req=010 rises 2 cycles into HOLDOFF=16 and stays high.
  - Expected: grant occurs on first IDLE cycle after HOLDOFF; a 1-cycle req glitch inside HOLDOFF produces no grant.
